// File: rtl/adc_pkg.sv
// Shared state encoding, framing constants and length clamp for the ADC frame reader.
package adc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    LEN_H,
    LEN_L,
    FETCH,
    WAIT_RD,
    PAYLOAD,
    CSUM,
    RELEASE
  } frame_state_t;

  localparam logic [7:0] SYNC0_DEFAULT   = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT   = 8'h5A;
  localparam int         FRAME_OVERHEAD  = 5;
  localparam int         MAX_LEN_DEFAULT = 3000;

  // Compare on the full 32 bits so large captures never wrap into a short frame.
  function automatic logic [15:0] clamp_len(input logic [31:0] len, input int max_len);
    return (len > 32'(max_len)) ? 16'(max_len) : len[15:0];
  endfunction

endpackage

// File: rtl/adc_frame_tx_reg.sv
// Outgoing byte holding register: load shows the byte on the next cycle; data and
// valid hold while tx_rdy is low, and valid drops on acceptance unless reloaded.
module adc_frame_tx_reg
  import adc_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       load_vld,
  input  logic [7:0] load_dat,
  input  logic       tx_rdy,
  output logic [7:0] tx_dat,
  output logic       tx_vld
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tx_dat <= '0;
      tx_vld <= 1'b0;
    end else if (load_vld) begin
      tx_dat <= load_dat;
      tx_vld <= 1'b1;
    end else if (tx_vld && tx_rdy) begin
      tx_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_frame_reader.sv
// Drains the capture FIFO into a framed packet (sync, length, payload, checksum) on a
// valid/ready byte stream; stalls hold the current byte, payload runs at most 1 byte per 3 clk.
module adc_frame_reader
  import adc_pkg::*;
#(
  parameter int         MAX_LEN = MAX_LEN_DEFAULT,
  parameter logic [7:0] SYNC0   = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1   = SYNC1_DEFAULT
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        send_en,
  input  logic [31:0] len,
  input  logic [7:0]  rd_data,
  output logic        rd_req,
  output logic        buf_clear,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  frame_state_t state, state_nxt;
  logic         send_en_q;
  logic [15:0]  plen;
  logic [15:0]  cnt;
  logic [15:0]  cnt_inc;
  logic [7:0]   csum;
  logic         start;
  logic         xfer;
  logic         load_vld;
  logic [7:0]   load_dat;

  assign start   = (state == IDLE) && send_en && !send_en_q;
  assign xfer    = tx_valid && tx_ready;
  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      send_en_q <= 1'b0;
      plen      <= '0;
      cnt       <= '0;
      csum      <= '0;
    end else begin
      state     <= state_nxt;
      send_en_q <= send_en;
      if (start) begin
        plen <= clamp_len(len, MAX_LEN);
        cnt  <= '0;
        csum <= '0;
      end
      if (state == WAIT_RD) csum <= csum + rd_data;
      if (state == PAYLOAD && xfer) cnt <= cnt_inc;
    end
  end

  // Each presenting state is loaded on the edge that enters it, so tx_valid is registered.
  always_comb begin
    state_nxt  = state;
    load_vld   = 1'b0;
    load_dat   = 8'h00;
    rd_req     = 1'b0;
    buf_clear  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: if (start) begin
        state_nxt = HDR0;
        load_vld  = 1'b1;
        load_dat  = SYNC0;
      end
      HDR0: if (xfer) begin
        state_nxt = HDR1;
        load_vld  = 1'b1;
        load_dat  = SYNC1;
      end
      HDR1: if (xfer) begin
        state_nxt = LEN_H;
        load_vld  = 1'b1;
        load_dat  = plen[15:8];
      end
      LEN_H: if (xfer) begin
        state_nxt = LEN_L;
        load_vld  = 1'b1;
        load_dat  = plen[7:0];
      end
      LEN_L: if (xfer) begin
        if (plen == 16'd0) begin
          state_nxt = CSUM;
          load_vld  = 1'b1;
          load_dat  = csum;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        rd_req    = 1'b1;
        state_nxt = WAIT_RD;
      end
      WAIT_RD: begin
        state_nxt = PAYLOAD;
        load_vld  = 1'b1;
        load_dat  = rd_data;
      end
      PAYLOAD: if (xfer) begin
        if (cnt_inc == plen) begin
          state_nxt = CSUM;
          load_vld  = 1'b1;
          load_dat  = csum;
        end else begin
          state_nxt = FETCH;
        end
      end
      CSUM: if (xfer) state_nxt = RELEASE;
      RELEASE: begin
        buf_clear  = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  adc_frame_tx_reg u_tx_reg (
    .clk      (clk),
    .clear    (clear),
    .load_vld (load_vld),
    .load_dat (load_dat),
    .tx_rdy   (tx_ready),
    .tx_dat   (tx_data),
    .tx_vld   (tx_valid)
  );

endmodule

// File: tb/tb_adc_frame_reader.sv
// Directed bench for adc_frame_reader: FIFO model, stream capture, per-scenario checks.
module tb_adc_frame_reader;
  import adc_pkg::*;

  logic        clk = 1'b0;
  logic        clear;
  logic        send_en;
  logic [31:0] len;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_req;
  logic        buf_clear;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo_mem [0:8191];
  logic [7:0] rx_mem   [0:8191];
  int rd_cnt    = 0;
  int rx_cnt    = 0;
  int clr_cnt   = 0;
  int done_cnt  = 0;
  int clr_at_rx = 0;

  adc_frame_reader dut (
    .clk        (clk),
    .clear      (clear),
    .send_en    (send_en),
    .len        (len),
    .rd_data    (rd_data),
    .rd_req     (rd_req),
    .buf_clear  (buf_clear),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next posedge will see.
  always @(negedge clk) begin
    if (rd_req) begin
      rd_data = fifo_mem[rd_cnt % 8192];
      rd_cnt  = rd_cnt + 1;
    end
    if (tx_valid && tx_ready) begin
      rx_mem[rx_cnt % 8192] = tx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (buf_clear) begin
      clr_cnt   = clr_cnt + 1;
      clr_at_rx = rx_cnt;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic launch(input logic [31:0] l);
    @(posedge clk); #1;
    len     = l;
    send_en = 1'b1;
  endtask

  task automatic drop_send_en();
    @(posedge clk); #1;
    send_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear    = 1'b1;
    send_en  = 1'b0;
    len      = 32'd0;
    tx_ready = 1'b1;
    #12;
    checks++;
    if ({busy, rd_req, buf_clear, tx_valid, frame_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy, rd_req, buf_clear, tx_valid, frame_done});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data got=%02h exp=00", tx_data);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_len4();
    int b_rx, b_rd, b_clr, b_done;
    bit ok;
    logic [7:0] exp [9];
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    b_rd = rd_cnt; b_rx = rx_cnt; b_clr = clr_cnt; b_done = done_cnt;
    for (int k = 0; k < 4; k++) fifo_mem[(b_rd + k) % 8192] = 8'(k + 1);
    launch(32'd4);
    wait_done(b_done + 1, 200, ok);
    drop_send_en();
    checks++;
    if (!ok) begin failures++; $display("FAIL len4_timeout got=no_frame_done exp=frame_done"); end
    checks++;
    if (rx_cnt - b_rx !== 4 + FRAME_OVERHEAD) begin
      failures++;
      $display("FAIL len4_count got=%0d exp=%0d", rx_cnt - b_rx, 4 + FRAME_OVERHEAD);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (rx_mem[(b_rx + k) % 8192] !== exp[k]) begin
        failures++;
        $display("FAIL len4_byte%0d got=%02h exp=%02h", k, rx_mem[(b_rx + k) % 8192], exp[k]);
      end
    end
    checks++;
    if (rd_cnt - b_rd !== 4) begin failures++; $display("FAIL len4_rd_req got=%0d exp=4", rd_cnt - b_rd); end
    checks++;
    if (clr_cnt - b_clr !== 1) begin failures++; $display("FAIL len4_buf_clear got=%0d exp=1", clr_cnt - b_clr); end
    checks++;
    if (clr_at_rx !== b_rx + 9) begin
      failures++;
      $display("FAIL len4_clear_after_last got=%0d exp=%0d", clr_at_rx - b_rx, 9);
    end
  endtask

  task automatic test_len0();
    int b_rx, b_rd, b_clr, b_done;
    bit ok;
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    b_rd = rd_cnt; b_rx = rx_cnt; b_clr = clr_cnt; b_done = done_cnt;
    launch(32'd0);
    wait_done(b_done + 1, 100, ok);
    drop_send_en();
    checks++;
    if (!ok) begin failures++; $display("FAIL len0_timeout got=no_frame_done exp=frame_done"); end
    checks++;
    if (rx_cnt - b_rx !== FRAME_OVERHEAD) begin
      failures++;
      $display("FAIL len0_count got=%0d exp=%0d", rx_cnt - b_rx, FRAME_OVERHEAD);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx_mem[(b_rx + k) % 8192] !== exp[k]) begin
        failures++;
        $display("FAIL len0_byte%0d got=%02h exp=%02h", k, rx_mem[(b_rx + k) % 8192], exp[k]);
      end
    end
    checks++;
    if (rd_cnt - b_rd !== 0) begin failures++; $display("FAIL len0_rd_req got=%0d exp=0", rd_cnt - b_rd); end
    checks++;
    if (clr_cnt - b_clr !== 1) begin failures++; $display("FAIL len0_buf_clear got=%0d exp=1", clr_cnt - b_clr); end
  endtask

  task automatic test_clamp(input logic [31:0] l, input string name);
    int b_rx, b_rd, b_done, bad;
    bit ok;
    logic [7:0] sum, b;
    b_rd = rd_cnt; b_rx = rx_cnt; b_done = done_cnt;
    sum = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      b = 8'((k * 37 + 11) & 255);
      fifo_mem[(b_rd + k) % 8192] = b;
      sum = sum + b;
    end
    launch(l);
    wait_done(b_done + 1, 12000, ok);
    drop_send_en();
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_timeout got=no_frame_done exp=frame_done", name); end
    checks++;
    if (rx_cnt - b_rx !== 3000 + FRAME_OVERHEAD) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, rx_cnt - b_rx, 3000 + FRAME_OVERHEAD);
    end
    checks++;
    if ({rx_mem[(b_rx + 2) % 8192], rx_mem[(b_rx + 3) % 8192]} !== 16'h0BB8) begin
      failures++;
      $display("FAIL %s_len got=%02h%02h exp=0BB8", name, rx_mem[(b_rx + 2) % 8192], rx_mem[(b_rx + 3) % 8192]);
    end
    checks++;
    if (rd_cnt - b_rd !== 3000) begin failures++; $display("FAIL %s_rd_req got=%0d exp=3000", name, rd_cnt - b_rd); end
    bad = 0;
    for (int k = 0; k < 3000; k++)
      if (rx_mem[(b_rx + 4 + k) % 8192] !== fifo_mem[(b_rd + k) % 8192]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s_payload got=%0d_bad_bytes exp=0", name, bad); end
    checks++;
    if (rx_mem[(b_rx + 3004) % 8192] !== sum) begin
      failures++;
      $display("FAIL %s_csum got=%02h exp=%02h", name, rx_mem[(b_rx + 3004) % 8192], sum);
    end
  endtask

  task automatic test_backpressure();
    int b_rx, b_rd, b_done, viol, stalls;
    bit prev_stall, finished;
    logic [7:0] prev_dat;
    logic [3:0] pat;
    logic [7:0] exp [8];
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h01};
    pat = 4'b1001;
    b_rd = rd_cnt; b_rx = rx_cnt; b_done = done_cnt;
    fifo_mem[(b_rd + 0) % 8192] = 8'hFF;
    fifo_mem[(b_rd + 1) % 8192] = 8'hFF;
    fifo_mem[(b_rd + 2) % 8192] = 8'h03;
    viol = 0; stalls = 0; prev_stall = 1'b0; prev_dat = 8'h00; finished = 1'b0;
    launch(32'd3);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      tx_ready = pat[i % 4];
      @(negedge clk);
      if (prev_stall && !(tx_valid && tx_data == prev_dat)) viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
      if (prev_stall) stalls++;
      if (done_cnt > b_done) begin
        finished = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    drop_send_en();
    checks++;
    if (!finished) begin failures++; $display("FAIL bp_timeout got=no_frame_done exp=frame_done"); end
    checks++;
    if (stalls == 0) begin failures++; $display("FAIL bp_stall_seen got=0 exp=nonzero"); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL bp_hold got=%0d_violations exp=0", viol); end
    checks++;
    if (rx_cnt - b_rx !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rx_cnt - b_rx); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rx_mem[(b_rx + k) % 8192] !== exp[k]) begin
        failures++;
        $display("FAIL bp_byte%0d got=%02h exp=%02h", k, rx_mem[(b_rx + k) % 8192], exp[k]);
      end
    end
    checks++;
    if (rd_cnt - b_rd !== 3) begin failures++; $display("FAIL bp_rd_req got=%0d exp=3", rd_cnt - b_rd); end
  endtask

  task automatic test_clear_midframe();
    int b_rx, b_rd, b_clr, b_done;
    bit found;
    b_rd = rd_cnt; b_rx = rx_cnt; b_clr = clr_cnt; b_done = done_cnt;
    for (int k = 0; k < 6; k++) fifo_mem[(b_rd + k) % 8192] = 8'(8'h40 + k);
    found = 1'b0;
    launch(32'd6);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (tx_valid && (rx_cnt - b_rx == 6)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reach_payload got=not_reached exp=third_payload_byte"); end
    clear = 1'b1;
    #1;
    checks++;
    if ({busy, rd_req, buf_clear, tx_valid, frame_done} !== 5'b0) begin
      failures++;
      $display("FAIL mid_async_ctrl got=%b exp=00000", {busy, rd_req, buf_clear, tx_valid, frame_done});
    end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_async_tx_data got=%02h exp=00", tx_data); end
    send_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (clr_cnt - b_clr !== 0) begin failures++; $display("FAIL mid_buf_clear got=%0d exp=0", clr_cnt - b_clr); end
    checks++;
    if (done_cnt - b_done !== 0) begin failures++; $display("FAIL mid_frame_done got=%0d exp=0", done_cnt - b_done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
  endtask

  task automatic test_send_en_held();
    int b_rx, b_rd, b_clr, b_done;
    bit ok;
    b_rd = rd_cnt; b_rx = rx_cnt; b_clr = clr_cnt; b_done = done_cnt;
    fifo_mem[(b_rd + 0) % 8192] = 8'h10;
    fifo_mem[(b_rd + 1) % 8192] = 8'h20;
    fifo_mem[(b_rd + 2) % 8192] = 8'h30;
    fifo_mem[(b_rd + 3) % 8192] = 8'h40;
    launch(32'd2);
    repeat (10000) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - b_done !== 1) begin failures++; $display("FAIL held_frames got=%0d exp=1", done_cnt - b_done); end
    checks++;
    if (clr_cnt - b_clr !== 1) begin failures++; $display("FAIL held_buf_clear got=%0d exp=1", clr_cnt - b_clr); end
    checks++;
    if (rx_cnt - b_rx !== 7) begin failures++; $display("FAIL held_count got=%0d exp=7", rx_cnt - b_rx); end
    checks++;
    if (rx_mem[(b_rx + 6) % 8192] !== 8'h30) begin
      failures++;
      $display("FAIL held_csum1 got=%02h exp=30", rx_mem[(b_rx + 6) % 8192]);
    end
    drop_send_en();
    launch(32'd2);
    wait_done(b_done + 2, 200, ok);
    drop_send_en();
    checks++;
    if (!ok) begin failures++; $display("FAIL rearm_timeout got=no_frame_done exp=frame_done"); end
    checks++;
    if (rx_cnt - b_rx !== 14) begin failures++; $display("FAIL rearm_count got=%0d exp=14", rx_cnt - b_rx); end
    checks++;
    if (rx_mem[(b_rx + 13) % 8192] !== 8'h70) begin
      failures++;
      $display("FAIL rearm_csum got=%02h exp=70", rx_mem[(b_rx + 13) % 8192]);
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_len0();
    test_clamp(32'd5000, "clamp5000");
    test_clamp(32'h0001_0004, "clamp_wide");
    test_backpressure();
    test_clear_midframe();
    test_send_en_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
